// File: rtl/i2c_target_adc_if.sv
// Pipeline-side handshake of the ADS1115-emulating I2C target: sample load in,
// config register and write strobes out.
interface i2c_target_adc_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] config_out;
    logic        config_wr;
    logic        os_start;

    modport master (
        output sample_in,
        output sample_valid,
        input  config_out,
        input  config_wr,
        input  os_start
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output config_out,
        output config_wr,
        output os_start
    );
endinterface

// File: rtl/i2c_target_adc.sv
// I2C target emulating the ADS1115 register map (conversion/config/lo/hi) at a fixed address.
// Optional input glitch filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_adc #(
    parameter logic [6:0]  I2C_ADDRESS = 7'h48,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scl,
    inout  wire             sda,
    i2c_target_adc_if.slave dbus,
    output logic            busy,
    output logic [3:0]      debug_state
);
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] ADDR       = 4'd1;
    localparam logic [3:0] ADDR_ACK   = 4'd2;
    localparam logic [3:0] PTR        = 4'd3;
    localparam logic [3:0] PTR_ACK    = 4'd4;
    localparam logic [3:0] WR_MSB     = 4'd5;
    localparam logic [3:0] WR_MSB_ACK = 4'd6;
    localparam logic [3:0] WR_LSB     = 4'd7;
    localparam logic [3:0] WR_LSB_ACK = 4'd8;
    localparam logic [3:0] RD_BYTE    = 4'd9;
    localparam logic [3:0] RD_ACK     = 4'd10;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_filt, sda_filt;
    logic       scl_prev, sda_prev;
    logic       scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
    logic [CNT_W-1:0] scl_cnt, sda_cnt;
    logic             scl_done, sda_done;

    assign scl_done = (scl_cnt == CNT_W'(FILTER_LEN - 1));
    assign sda_done = (sda_cnt == CNT_W'(FILTER_LEN - 1));

    // A line flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            if (scl_sync[1] == scl_filt || scl_done) scl_cnt <= '0;
            else                                     scl_cnt <= scl_cnt + 1'b1;
            if (scl_sync[1] != scl_filt && scl_done) scl_filt <= scl_sync[1];
            if (sda_sync[1] == sda_filt || sda_done) sda_cnt <= '0;
            else                                     sda_cnt <= sda_cnt + 1'b1;
            if (sda_sync[1] != sda_filt && sda_done) sda_filt <= sda_sync[1];
        end
    end
`else
    assign scl_filt = scl_sync[1];
    assign sda_filt = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_filt;
            sda_prev <= sda_filt;
        end
    end

    assign scl_rise  = scl_filt & ~scl_prev;
    assign scl_fall  = ~scl_filt & scl_prev;
    assign start_det = scl_filt & scl_prev & sda_prev & ~sda_filt;
    assign stop_det  = scl_filt & scl_prev & ~sda_prev & sda_filt;

    logic [3:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  sr_q, sr_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic [7:0]  msb_q, msb_d, lsb_q, lsb_d;
    logic [15:0] shadow_q, shadow_d;
    logic        lsb_sel_q, lsb_sel_d;
    logic        drv_q, drv_d;
    logic        busy_q, busy_d;
    logic [15:0] conv_q, conv_d, cfg_q, cfg_d, lo_q, lo_d, hi_q, hi_d;
    logic        cfg_wr_q, cfg_wr_d, os_q, os_d;
    logic [7:0]  byte_in;
    logic [15:0] rd_val;

    assign byte_in = {sr_q, sda_filt};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        msb_d     = msb_q;
        lsb_d     = lsb_q;
        shadow_d  = shadow_q;
        lsb_sel_d = lsb_sel_q;
        drv_d     = drv_q;
        conv_d    = dbus.sample_valid ? dbus.sample_in : conv_q;
        cfg_d     = cfg_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        cfg_wr_d  = 1'b0;
        os_d      = 1'b0;

        // A sample arriving in the capture cycle wins for a conversion read.
        case (ptr_q)
            2'd0:    rd_val = conv_d;
            2'd1:    rd_val = {1'b1, cfg_q[14:0]};
            2'd2:    rd_val = lo_q;
            default: rd_val = hi_q;
        endcase

        if (stop_det) begin
            state_d = IDLE;
            drv_d   = 1'b0;
        end else if (start_det) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            drv_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR, PTR, WR_MSB, WR_LSB: begin
                    if (scl_rise) begin
                        sr_d  = byte_in[6:0];
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            case (state_q)
                                ADDR: begin
                                    if (byte_in[7:1] == I2C_ADDRESS) begin
                                        state_d   = ADDR_ACK;
                                        rw_d      = byte_in[0];
                                        shadow_d  = rd_val;
                                        lsb_sel_d = 1'b0;
                                    end else begin
                                        state_d = IDLE;
                                    end
                                end
                                PTR: begin
                                    state_d = PTR_ACK;
                                    ptr_d   = byte_in[1:0];
                                end
                                WR_MSB: begin
                                    state_d = WR_MSB_ACK;
                                    msb_d   = byte_in;
                                end
                                default: begin
                                    state_d = WR_LSB_ACK;
                                    lsb_d   = byte_in;
                                end
                            endcase
                        end
                    end
                end
                // drv_q doubles as the ACK phase: first fall drives, second releases.
                ADDR_ACK, PTR_ACK, WR_MSB_ACK, WR_LSB_ACK: begin
                    if (scl_fall) begin
                        if (!drv_q) begin
                            drv_d = 1'b1;
                        end else begin
                            drv_d = 1'b0;
                            case (state_q)
                                ADDR_ACK: begin
                                    if (rw_q) begin
                                        state_d = RD_BYTE;
                                        drv_d   = ~shadow_q[15];
                                    end else begin
                                        state_d = PTR;
                                    end
                                end
                                PTR_ACK:    state_d = WR_MSB;
                                WR_MSB_ACK: state_d = WR_LSB;
                                default: begin
                                    state_d = WR_MSB;
                                    case (ptr_q)
                                        2'd1: begin
                                            cfg_d    = {1'b0, msb_q[6:0], lsb_q};
                                            cfg_wr_d = 1'b1;
                                            os_d     = msb_q[7];
                                        end
                                        2'd2:    lo_d = {msb_q, lsb_q};
                                        2'd3:    hi_d = {msb_q, lsb_q};
                                        default: ;
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            drv_d   = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = RD_ACK;
                        end else begin
                            drv_d = ~shadow_q[{~lsb_sel_q, ~cnt_q[2:0]}];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_filt) begin
                        state_d = IDLE;
                    end else if (scl_fall) begin
                        state_d   = RD_BYTE;
                        lsb_sel_d = ~lsb_sel_q;
                        drv_d     = ~shadow_q[{lsb_sel_q, 3'b111}];
                    end
                end
                default: begin
                    state_d = IDLE;
                    drv_d   = 1'b0;
                end
            endcase
        end

        if (state_d == ADDR_ACK) busy_d = 1'b1;
        else if (state_d == IDLE) busy_d = 1'b0;
        else                      busy_d = busy_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sr_q      <= 7'd0;
            ptr_q     <= 2'd0;
            rw_q      <= 1'b0;
            msb_q     <= 8'd0;
            lsb_q     <= 8'd0;
            shadow_q  <= 16'd0;
            lsb_sel_q <= 1'b0;
            drv_q     <= 1'b0;
            busy_q    <= 1'b0;
            conv_q    <= 16'h0000;
            cfg_q     <= 16'h0583;
            lo_q      <= 16'h8000;
            hi_q      <= 16'h7FFF;
            cfg_wr_q  <= 1'b0;
            os_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            msb_q     <= msb_d;
            lsb_q     <= lsb_d;
            shadow_q  <= shadow_d;
            lsb_sel_q <= lsb_sel_d;
            drv_q     <= drv_d;
            busy_q    <= busy_d;
            conv_q    <= conv_d;
            cfg_q     <= cfg_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            cfg_wr_q  <= cfg_wr_d;
            os_q      <= os_d;
        end
    end

    assign sda             = drv_q ? 1'b0 : 1'bz;
    assign busy            = busy_q;
    assign debug_state     = state_q;
    assign dbus.config_out = cfg_q;
    assign dbus.config_wr  = cfg_wr_q;
    assign dbus.os_start   = os_q;
endmodule

// File: tb/tb_i2c_target_adc.sv
// Bench for i2c_target_adc: bit-banged I2C controller, register table and read-byte scoreboard.
module tb_i2c_target_adc;
    localparam int T = 100;

    typedef struct {
        int          kind;     // 0 full write, 1 repeated-start read, 2 MSB-only write
        logic [1:0]  ptr;
        logic [15:0] data;     // write data, or expected read value
        logic [15:0] exp_cfg;
        int          exp_wr;
        int          exp_os;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       ctl_low = 1'b0;
    wire        sda_bus;
    logic       busy;
    logic [3:0] debug_state;

    i2c_target_adc_if dbus ();

    assign sda_bus = ctl_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_target_adc #(
        .I2C_ADDRESS(7'h48),
        .FILTER_LEN (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl        (scl),
        .sda        (sda_bus),
        .dbus       (dbus),
        .busy       (busy),
        .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         wr_cnt = 0;
    int         os_cnt = 0;
    bit         mon_en = 1'b0;
    bit         dut_drove = 1'b0;
    bit         busy_seen = 1'b0;
    logic [7:0] sb[$];
    vec_t       tbl[12];

    always @(negedge clk) begin
        if (dbus.config_wr) wr_cnt++;
        if (dbus.os_start) os_cnt++;
        if (mon_en && !ctl_low && sda_bus == 1'b0) dut_drove = 1'b1;
        if (mon_en && busy) busy_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic pulse_sample(input logic [15:0] v);
        @(negedge clk);
        dbus.sample_in    = v;
        dbus.sample_valid = 1'b1;
        @(negedge clk);
        dbus.sample_valid = 1'b0;
    endtask

    task automatic i2c_start();
        ctl_low = 1'b1;
        #T scl = 1'b0;
        #T;
    endtask

    task automatic i2c_rstart();
        ctl_low = 1'b0;
        #T scl = 1'b1;
        #T i2c_start();
    endtask

    task automatic i2c_stop();
        ctl_low = 1'b1;
        #T scl = 1'b1;
        #T ctl_low = 1'b0;
        #(2 * T);
    endtask

    task automatic put_bit(input bit b);
        ctl_low = !b;
        #T scl = 1'b1;
        #(2 * T) scl = 1'b0;
        #T;
    endtask

    task automatic get_bit(output bit b);
        ctl_low = 1'b0;
        #T scl = 1'b1;
        #T b = sda_bus;
        #T scl = 1'b0;
        #T;
    endtask

    task automatic put_byte(input logic [7:0] v, output bit ack);
        bit a;
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(a);
        ack = !a;
    endtask

    // Reads a byte, optionally loads a new sample mid-byte, then compares against the scoreboard.
    task automatic get_byte_sb(input bit ack, input int upd_at, input logic [15:0] upd_val,
                               input string name);
        bit         bt;
        logic [7:0] b;
        logic [7:0] exp;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            get_bit(bt);
            b = {b[6:0], bt};
            if (i == upd_at) pulse_sample(upd_val);
        end
        put_bit(!ack);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got byte %0h, want none queued", name, b);
        end else begin
            exp = sb.pop_front();
            check(name, {24'd0, b}, {24'd0, exp});
        end
    endtask

    task automatic write_ptr_prefix(input logic [1:0] ptr, input string name);
        bit ack;
        i2c_start();
        put_byte(8'h90, ack);
        check($sformatf("%s addr ack", name), {31'd0, ack}, 32'd1);
        check($sformatf("%s busy", name), {31'd0, busy}, 32'd1);
        put_byte({6'd0, ptr}, ack);
        check($sformatf("%s ptr ack", name), {31'd0, ack}, 32'd1);
    endtask

    task automatic read_tail(input logic [15:0] exp, input int upd_at, input logic [15:0] upd_val,
                             input string name);
        bit ack;
        put_byte(8'h91, ack);
        check($sformatf("%s rd addr ack", name), {31'd0, ack}, 32'd1);
        sb.push_back(exp[15:8]);
        sb.push_back(exp[7:0]);
        get_byte_sb(1'b1, upd_at, upd_val, $sformatf("%s msb", name));
        get_byte_sb(1'b0, -1, 16'h0, $sformatf("%s lsb", name));
        check($sformatf("%s nack release", name), {31'd0, sda_bus}, 32'd1);
        i2c_stop();
        check($sformatf("%s idle", name), {28'd0, debug_state}, 32'd0);
    endtask

    task automatic do_write(input logic [1:0] ptr, input logic [15:0] d, input bit msb_only,
                            input string name);
        bit ack;
        wr_cnt = 0;
        os_cnt = 0;
        write_ptr_prefix(ptr, name);
        put_byte(d[15:8], ack);
        check($sformatf("%s msb ack", name), {31'd0, ack}, 32'd1);
        if (!msb_only) begin
            put_byte(d[7:0], ack);
            check($sformatf("%s lsb ack", name), {31'd0, ack}, 32'd1);
        end
        i2c_stop();
        check($sformatf("%s busy after stop", name), {31'd0, busy}, 32'd0);
    endtask

    task automatic do_read(input logic [1:0] ptr, input logic [15:0] exp, input bit use_sr,
                           input string name);
        write_ptr_prefix(ptr, name);
        if (use_sr) begin
            i2c_rstart();
        end else begin
            i2c_stop();
            i2c_start();
        end
        read_tail(exp, -1, 16'h0, name);
    endtask

    initial begin
        #(900000);
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit ack;
        dbus.sample_in    = 16'h0;
        dbus.sample_valid = 1'b0;

        tbl[0]  = '{0, 2'd1, 16'hC3E3, 16'h43E3, 1, 1};
        tbl[1]  = '{1, 2'd1, 16'hC3E3, 16'h0, 0, 0};
        tbl[2]  = '{1, 2'd2, 16'h8000, 16'h0, 0, 0};
        tbl[3]  = '{1, 2'd3, 16'h7FFF, 16'h0, 0, 0};
        tbl[4]  = '{0, 2'd2, 16'h1357, 16'h43E3, 0, 0};
        tbl[5]  = '{1, 2'd2, 16'h1357, 16'h0, 0, 0};
        tbl[6]  = '{0, 2'd1, 16'h0123, 16'h0123, 1, 0};
        tbl[7]  = '{1, 2'd1, 16'h8123, 16'h0, 0, 0};
        tbl[8]  = '{0, 2'd0, 16'hFFFF, 16'h0123, 0, 0};
        tbl[9]  = '{1, 2'd0, 16'h0000, 16'h0, 0, 0};
        tbl[10] = '{2, 2'd3, 16'hAA00, 16'h0123, 0, 0};
        tbl[11] = '{1, 2'd3, 16'h7FFF, 16'h0, 0, 0};

        #(3 * T) rst_n = 1'b1;
        #(2 * T);
        check("reset sda", {31'd0, sda_bus}, 32'd1);
        check("reset config_out", {16'd0, dbus.config_out}, 32'h0583);
        check("reset config_wr", {31'd0, dbus.config_wr}, 32'd0);
        check("reset os_start", {31'd0, dbus.os_start}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset state", {28'd0, debug_state}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].kind == 1) begin
                do_read(tbl[i].ptr, tbl[i].data, 1'b1, $sformatf("v%0d", i));
            end else begin
                do_write(tbl[i].ptr, tbl[i].data, tbl[i].kind == 2, $sformatf("v%0d", i));
                check($sformatf("v%0d config_out", i), {16'd0, dbus.config_out},
                      {16'd0, tbl[i].exp_cfg});
                check($sformatf("v%0d config_wr pulses", i), wr_cnt, tbl[i].exp_wr);
                check($sformatf("v%0d os_start pulses", i), os_cnt, tbl[i].exp_os);
            end
        end

        // Extra data bytes keep overwriting the same register.
        write_ptr_prefix(2'd2, "extra");
        put_byte(8'h11, ack);
        put_byte(8'h22, ack);
        put_byte(8'h33, ack);
        put_byte(8'h44, ack);
        check("extra 4th byte ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        do_read(2'd2, 16'h3344, 1'b1, "extra rd");

        // Conversion read via separate pointer-write transaction.
        pulse_sample(16'h1234);
        do_read(2'd0, 16'h1234, 1'b0, "conv");

        // New sample mid-read must not disturb the captured shadow.
        i2c_start();
        read_tail(16'h1234, 3, 16'hABCD, "shadow");
        i2c_start();
        read_tail(16'hABCD, -1, 16'h0, "shadow next");

        // Wrong address: never ACKed, never driven, never busy.
        dut_drove = 1'b0;
        busy_seen = 1'b0;
        mon_en    = 1'b1;
        i2c_start();
        put_byte(8'h92, ack);
        check("mismatch addr ack", {31'd0, ack}, 32'd0);
        put_byte(8'h00, ack);
        check("mismatch data ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        mon_en = 1'b0;
        check("mismatch sda driven", {31'd0, dut_drove}, 32'd0);
        check("mismatch busy seen", {31'd0, busy_seen}, 32'd0);

        // Reset while the target drives a 0 data bit.
        pulse_sample(16'h0F0F);
        i2c_start();
        put_byte(8'h91, ack);
        check("midrst addr ack", {31'd0, ack}, 32'd1);
        check("midrst drive 0", {31'd0, sda_bus}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst sda released", {31'd0, sda_bus}, 32'd1);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst state", {28'd0, debug_state}, 32'd0);
        #T scl = 1'b1;
        #T rst_n = 1'b1;
        #(4 * T);
        check("post reset config_out", {16'd0, dbus.config_out}, 32'h0583);
        check("scoreboard drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
